golden_nonce_tracker: RTL and testbench
=======================================

Name: golden_nonce_tracker

Overview:
- Parametrised nonce sequencer and result qualifier for the double-SHA-256 miner, generalised to NUM_CORES parallel hashers and any LOOP_LOG2 rolling factor.
- Issues nonces to the cores and suppresses stale results after a work load.
- Reconstructs the nonce belonging to each emerging hash, compares its top word against a programmable target, and queues golden nonces in a FIFO for the serial transmitter.

Parameters:
- LOOP_LOG2, 0: rolling factor; a new nonce group issues every LOOP = 2^LOOP_LOG2 cycles (0..5).
- NUM_CORES, 1: parallel hasher count, power of two, 1..8; core k hashes nonce_out+k.
- PIPE_DEPTH, 131: issues in flight between nonce issue and the matching hash word at hash_word_in.
- FIFO_DEPTH, 4: golden-nonce FIFO entries, power of two, 2..16.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- work_valid, in, 1: one-cycle pulse; new work loaded.
- work_nonce, in, 32: first nonce of the new work.
- target, in, 32: hit when hash word <= target (0 = difficulty 1).
- hash_word_in, in, 32*NUM_CORES: final H7 word per core; core k occupies bits [32k+31:32k].
- nonce_out, out, 32: base nonce for the current issue group.
- issue, out, 1: pulse on cycles where the cores sample nonce_out.
- gn_data, out, 32: FIFO head golden nonce.
- gn_valid, out, 1: FIFO non-empty.
- gn_ready, in, 1: pop; a transfer occurs when gn_valid && gn_ready.
- multi_hit, out, 1: sticky; more than one core hit in the same issue.
- overflow_cnt, out, 8: saturating count of hits dropped while the FIFO was full.
- wrapped, out, 1: one-cycle pulse when nonce_out wraps past 0xFFFFFFFF.

Behaviour:
- Reset values: nonce_out=0, issue=0, phase=0, warm=0, FIFO empty, gn_valid=0, gn_data=0, multi_hit=0, overflow_cnt=0, wrapped=0.
- Reset is asynchronous; asserting it mid-operation discards all state.
- Phase counter: LOG2 width, counts 0..LOOP-1 and wraps.
  - issue=1 when phase==LOOP-1.
  - When LOOP=1, issue=1 every cycle.
- On issue:
  - nonce_out <= nonce_out + NUM_CORES, modulo 2^32.
  - wrapped pulses when the sum carries out of bit 31.
- Work load: on work_valid, next cycle nonce_out=work_nonce, phase=0, warm=0, FIFO flushed.
  - work_valid has priority over issue, hit, and pop in the same cycle.
  - multi_hit and overflow_cnt are not cleared by work_valid.
- Warm-up: warm counts issues since the last load, saturating at PIPE_DEPTH.
  - Results are qualified only on issue cycles with warm==PIPE_DEPTH.
  - The first PIPE_DEPTH issues after load or reset produce no hits.
- Result nonce for core k on a qualified issue cycle = nonce_out - PIPE_DEPTH*NUM_CORES + k, modulo 2^32.
  - The result is combinational from the registered nonce_out.
- Hit for core k: hash_word_in[k] <= target, unsigned.
- Multiple hits in one issue:
  - Enqueue the lowest-index hitting core only.
  - Set multi_hit sticky.
  - Do not count the extra hits as overflow.
- FIFO behaviour:
  - First-word-fall-through: gn_data is valid in the same cycle gn_valid is high.
  - Push latency: hit on cycle t gives gn_valid=1 at t+1 (if previously empty).
  - Push and pop in the same cycle are both performed, including when full.
  - Push when full without a pop: the hit is dropped and overflow_cnt increments, saturating at 255.
  - Pop when empty is ignored.
  - gn_data holds its last value when the FIFO is empty.
- Work load mid-flight: in-flight results of the old work are suppressed by the warm reset.

Test Plan:
- Reset then load: reset_n low, then work_valid with work_nonce=0x195A2C52, LOOP_LOG2=0, NUM_CORES=1 -> issue every cycle; nonce_out 0x195A2C52, 0x195A2C53, ...; gn_valid stays 0 for 131 issues.
- Single hit, PIPE_DEPTH=4, target=0: after warm-up, drive hash_word_in=0 on the issue where nonce_out=0x1000000A -> next cycle gn_valid=1, gn_data=0x10000006; pop with gn_ready=1 -> gn_valid=0.
- Multi-core, NUM_CORES=4, LOOP_LOG2=1, PIPE_DEPTH=2, work_nonce=0x100: nonce_out steps by 4 every 2 cycles; hits on cores 1 and 3 at nonce_out=0x110 -> enqueue 0x109, multi_hit=1.
- Overflow, FIFO_DEPTH=2, gn_ready=0: three qualified hits -> gn_valid=1, two entries retained (first two nonces), overflow_cnt=1; a hit with simultaneous pop while full -> overflow_cnt unchanged.
- Wrap: work_nonce=0xFFFFFFFE, NUM_CORES=2 -> after one issue nonce_out=0x00000000 and wrapped pulses for one cycle; a hit with PIPE_DEPTH=1 reports 0xFFFFFFFE.
- Load mid-operation: FIFO holding 2 entries with a hit pending; assert work_valid the same cycle as gn_ready and a hit -> FIFO empty next cycle, nonce_out=work_nonce, no hits for PIPE_DEPTH issues.

Source files
------------

// File: rtl/golden_nonce_tracker.sv
// Nonce sequencer and golden-nonce qualifier for an array of rolled double-SHA-256 cores.
// Hits are queued in a small first-word-fall-through FIFO drained by the serial transmitter.

// Generic FWFT FIFO with synchronous flush; the head holds its last value when empty.
// Latency: a push is visible at out_vld/out_dat on the next cycle.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module gnt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    assign out_vld = (count_q != '0);
    assign full    = (count_q == FULL_CNT);
    assign out_dat = out_vld ? mem_q[rd_ptr_q] : last_q;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_rdy && out_vld && !flush;
    assign do_push = push_vld && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = out_dat;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// Issues nonce groups every 2^LOOP_LOG2 cycles and qualifies hashes returning PIPE_DEPTH issues later.
// Latency: hit on a qualified issue cycle appears at gn_valid/gn_data one cycle later.
// Backpressure: gn_ready pops the FIFO; hits arriving while it is full are dropped and counted.
module golden_nonce_tracker #(
    parameter int LOOP_LOG2  = 0,
    parameter int NUM_CORES  = 1,
    parameter int PIPE_DEPTH = 131,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   work_valid,
    input  logic [31:0]            work_nonce,
    input  logic [31:0]            target,
    input  logic [32*NUM_CORES-1:0] hash_word_in,
    output logic [31:0]            nonce_out,
    output logic                   issue,
    output logic [31:0]            gn_data,
    output logic                   gn_valid,
    input  logic                   gn_ready,
    output logic                   multi_hit,
    output logic [7:0]             overflow_cnt,
    output logic                   wrapped
);
    localparam int LOOP = 1 << LOOP_LOG2;
    localparam int PW   = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
    localparam int WW   = $clog2(PIPE_DEPTH + 1);
    localparam int SW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(LOOP - 1);
    localparam logic [WW-1:0] WARM_FULL  = WW'(PIPE_DEPTH);
    localparam logic [31:0]   BACKOFF    = 32'(PIPE_DEPTH * NUM_CORES);

    logic [PW-1:0] phase_q, phase_d;
    logic          issue_q, issue_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [WW-1:0] warm_q, warm_d;
    logic          wrapped_q, wrapped_d;
    logic          multi_q, multi_d;
    logic [7:0]    ovf_q, ovf_d;

    logic [NUM_CORES-1:0] hit_vec;
    logic [SW-1:0]        hit_sel;
    logic                 hit_multi;
    logic                 qualified;
    logic                 push_vld;
    logic [31:0]          push_dat;
    logic                 pop;
    logic                 fifo_full;
    logic [32:0]          nonce_sum;

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            hit_vec[k] = (hash_word_in[32*k +: 32] <= target);
        end
    end

    // Lowest-index hitting core wins; extra hits only raise multi_hit.
    always_comb begin
        hit_sel = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_sel = SW'(k);
            end
        end
    end

    assign hit_multi = |(hit_vec & (hit_vec - NUM_CORES'(1)));
    assign qualified = issue_q && !work_valid && (warm_q == WARM_FULL);
    assign push_vld  = qualified && (|hit_vec);
    // The hash at the input now belongs to the group issued PIPE_DEPTH issues ago.
    assign push_dat  = nonce_q - BACKOFF + 32'(hit_sel);
    assign pop       = gn_valid && gn_ready && !work_valid;
    assign nonce_sum = {1'b0, nonce_q} + 33'(NUM_CORES);

    always_comb begin
        phase_d   = phase_q;
        nonce_d   = nonce_q;
        warm_d    = warm_q;
        wrapped_d = 1'b0;
        multi_d   = multi_q;
        ovf_d     = ovf_q;
        if (work_valid) begin
            phase_d = '0;
            nonce_d = work_nonce;
            warm_d  = '0;
        end else begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
            if (issue_q) begin
                nonce_d   = nonce_sum[31:0];
                wrapped_d = nonce_sum[32];
                if (warm_q != WARM_FULL) begin
                    warm_d = warm_q + WW'(1);
                end
            end
            if (qualified && hit_multi) begin
                multi_d = 1'b1;
            end
            if (push_vld && fifo_full && !pop && (ovf_q != 8'hFF)) begin
                ovf_d = ovf_q + 8'd1;
            end
        end
        issue_d = (phase_d == PHASE_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            issue_q   <= 1'b0;
            nonce_q   <= '0;
            warm_q    <= '0;
            wrapped_q <= 1'b0;
            multi_q   <= 1'b0;
            ovf_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            issue_q   <= issue_d;
            nonce_q   <= nonce_d;
            warm_q    <= warm_d;
            wrapped_q <= wrapped_d;
            multi_q   <= multi_d;
            ovf_q     <= ovf_d;
        end
    end

    gnt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_gn_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (work_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .out_vld  (gn_valid),
        .out_dat  (gn_data),
        .full     (fifo_full)
    );

    assign nonce_out    = nonce_q;
    assign issue        = issue_q;
    assign wrapped      = wrapped_q;
    assign multi_hit    = multi_q;
    assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_golden_nonce_tracker.sv
// Bench for golden_nonce_tracker: a reference model and golden-nonce queue checked every cycle,
// plus directed scenarios with hand-derived expected values.
module tb_golden_nonce_tracker;
    localparam int LL   = 1;
    localparam int LOOP = 1 << LL;
    localparam int NC   = 4;
    localparam int PD   = 2;
    localparam int FD   = 2;
    localparam logic [127:0] NO_HIT = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n;
    logic         work_valid;
    logic [31:0]  work_nonce;
    logic [31:0]  target;
    logic [127:0] hash_word_in;
    logic [31:0]  nonce_out;
    logic         issue;
    logic [31:0]  gn_data;
    logic         gn_valid;
    logic         gn_ready;
    logic         multi_hit;
    logic [7:0]   overflow_cnt;
    logic         wrapped;

    always #5 clk = ~clk;

    golden_nonce_tracker #(
        .LOOP_LOG2  (LL),
        .NUM_CORES  (NC),
        .PIPE_DEPTH (PD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .work_valid   (work_valid),
        .work_nonce   (work_nonce),
        .target       (target),
        .hash_word_in (hash_word_in),
        .nonce_out    (nonce_out),
        .issue        (issue),
        .gn_data      (gn_data),
        .gn_valid     (gn_valid),
        .gn_ready     (gn_ready),
        .multi_hit    (multi_hit),
        .overflow_cnt (overflow_cnt),
        .wrapped      (wrapped)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state; m_q is the scoreboard of golden nonces awaiting transfer.
    logic        m_issue;
    int          m_phase;
    logic [31:0] m_nonce;
    int          m_warm;
    logic        m_wrapped;
    logic        m_multi;
    int          m_ovf;
    logic [31:0] m_last;
    logic [31:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_issue = 1'b0; m_phase = 0; m_nonce = '0; m_warm = 0;
        m_wrapped = 1'b0; m_multi = 1'b0; m_ovf = 0; m_last = '0;
        m_q.delete();
    endtask

    function automatic logic [31:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : m_last;
    endfunction

    task automatic check_all();
        chk("issue", 32'(issue), 32'(m_issue));
        chk("nonce_out", nonce_out, m_nonce);
        chk("wrapped", 32'(wrapped), 32'(m_wrapped));
        chk("gn_valid", 32'(gn_valid), 32'(m_q.size() != 0));
        chk("gn_data", gn_data, m_head());
        chk("multi_hit", 32'(multi_hit), 32'(m_multi));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(m_ovf));
    endtask

    task automatic model_next();
        logic        pop;
        logic        qual;
        logic        push;
        logic [31:0] pdat;
        logic [32:0] sum;
        int          nh;
        pop  = (m_q.size() != 0) && gn_ready && !work_valid;
        qual = 1'b0;
        push = 1'b0;
        pdat = '0;
        if (work_valid) begin
            m_nonce = work_nonce; m_phase = 0; m_warm = 0; m_wrapped = 1'b0;
            m_q.delete();
        end else begin
            qual = m_issue && (m_warm == PD);
            if (qual) begin
                nh = 0;
                for (int k = 0; k < NC; k++) begin
                    if (hash_word_in[32*k +: 32] <= target) begin
                        if (nh == 0) pdat = m_nonce - 32'(PD * NC) + 32'(k);
                        nh++;
                    end
                end
                push = (nh > 0);
                if (nh > 1) m_multi = 1'b1;
            end
            if (m_issue) begin
                sum = {1'b0, m_nonce} + 33'(NC);
                m_nonce = sum[31:0];
                m_wrapped = sum[32];
                if (m_warm < PD) m_warm++;
            end else begin
                m_wrapped = 1'b0;
            end
            m_phase = (m_phase == LOOP - 1) ? 0 : m_phase + 1;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FD) m_q.push_back(pdat);
                else if (m_ovf < 255) m_ovf++;
            end
        end
        m_issue = (m_phase == LOOP - 1);
    endtask

    task automatic cycle();
        check_all();
        m_last = m_head();
        if (reset_n) model_next();
        else model_reset();
        @(posedge clk);
        #1;
    endtask

    // Advance until the model is on an issue cycle for nonce group n (bounded).
    task automatic to_issue(input logic [31:0] n);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_issue && m_nonce == n) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("to_issue_reached", 32'(found), 32'd1);
    endtask

    task automatic hit_at(input logic [31:0] n, input logic [127:0] h);
        to_issue(n);
        hash_word_in = h;
        cycle();
        hash_word_in = NO_HIT;
    endtask

    initial begin
        reset_n = 1'b1; work_valid = 1'b0; work_nonce = '0; target = '0;
        hash_word_in = NO_HIT; gn_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_nonce", nonce_out, 32'h0);
        chk("rst_valid", 32'(gn_valid), 32'd0);
        chk("rst_ovf", 32'(overflow_cnt), 32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
        cycle();
        cycle();

        // Multi-core load, hits on cores 1 and 3 at nonce_out 0x110.
        work_valid = 1'b1; work_nonce = 32'h100;
        cycle();
        work_valid = 1'b0;
        chk("load_nonce", nonce_out, 32'h100);
        hit_at(32'h110, {32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF});
        chk("mc_valid", 32'(gn_valid), 32'd1);
        chk("mc_data", gn_data, 32'h109);
        chk("mc_multi", 32'(multi_hit), 32'd1);
        gn_ready = 1'b1;
        cycle();
        gn_ready = 1'b0;
        chk("pop_empty", 32'(gn_valid), 32'd0);
        chk("hold_data", gn_data, 32'h109);

        // Target boundary: equal hits, one above does not.
        target = 32'h1234;
        hit_at(32'h118, {{3{32'h1235}}, 32'h1234});
        chk("eq_target_data", gn_data, 32'h110);
        gn_ready = 1'b1;
        cycle();
        gn_ready = 1'b0;
        hit_at(32'h11C, {4{32'h1235}});
        chk("above_target", 32'(gn_valid), 32'd0);

        // Overflow with FIFO_DEPTH 2, then a hit with pop while full.
        target = 32'h10;
        hit_at(32'h120, {NO_HIT[127:32], 32'h5});
        hit_at(32'h124, {NO_HIT[127:32], 32'h5});
        hit_at(32'h128, {NO_HIT[127:32], 32'h5});
        chk("ovf_cnt", 32'(overflow_cnt), 32'd1);
        chk("ovf_head", gn_data, 32'h118);
        to_issue(32'h12C);
        gn_ready = 1'b1; hash_word_in = {NO_HIT[127:32], 32'h5};
        cycle();
        gn_ready = 1'b0; hash_word_in = NO_HIT;
        chk("full_pushpop_ovf", 32'(overflow_cnt), 32'd1);
        chk("full_pushpop_head", gn_data, 32'h11C);

        // Load mid-operation with pop and hit pending, then wrap.
        to_issue(32'h130);
        work_valid = 1'b1; work_nonce = 32'hFFFFFFFC; gn_ready = 1'b1; hash_word_in = '0;
        cycle();
        work_valid = 1'b0; gn_ready = 1'b0;
        chk("load_flush", 32'(gn_valid), 32'd0);
        chk("load_nonce2", nonce_out, 32'hFFFFFFFC);
        to_issue(32'hFFFFFFFC);
        cycle();
        chk("wrap_nonce", nonce_out, 32'h0);
        chk("wrap_pulse", 32'(wrapped), 32'd1);
        cycle();
        chk("wrap_single", 32'(wrapped), 32'd0);
        hash_word_in = NO_HIT;
        hit_at(32'h4, {32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF});
        chk("wrap_result", gn_data, 32'hFFFFFFFE);

        // Overflow counter saturation.
        hash_word_in = '0;
        repeat (600) cycle();
        chk("ovf_sat", 32'(overflow_cnt), 32'd255);
        hash_word_in = NO_HIT;

        // Asynchronous reset between clock edges.
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_nonce", nonce_out, 32'h0);
        chk("arst_ovf", 32'(overflow_cnt), 32'd0);
        chk("arst_multi", 32'(multi_hit), 32'd0);
        cycle();
        reset_n = 1'b1;
        work_valid = 1'b1; work_nonce = 32'hFFFFFF80;
        cycle();
        work_valid = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            gn_ready = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < NC; k++) begin
                hash_word_in[32*k +: 32] = ($urandom_range(0, 4) == 0) ?
                    32'($urandom_range(0, 32'h10)) : 32'($urandom_range(32'h11, 32'hFFFFFFFF));
            end
            work_valid = ($urandom_range(0, 79) == 0);
            work_nonce = $urandom;
            cycle();
        end
        work_valid = 1'b0;
        hash_word_in = NO_HIT;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
